// File: rtl/vm_pkg.sv
// Shared types and helpers for the vending-machine controller: FSM state
// encoding and one-hot coin decoding.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        CHECK,
        DISPENSE,
        REFUND
    } vm_state_t;

    localparam logic [2:0] COIN_5  = 3'b001;
    localparam logic [2:0] COIN_10 = 3'b010;
    localparam logic [2:0] COIN_20 = 3'b100;

    // Any code that is not exactly one of the three coins is worth nothing.
    function automatic logic [4:0] coin_value(input logic [2:0] money);
        case (money)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_20: return 5'd20;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_stock.sv
// Per-item stock counters: bulk reload on restock, single decrement on dispense,
// and an empty flag for the currently selected item.
module vm_stock #(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = $clog2(NUM_ITEMS),
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restock,
    input  logic              dec,
    input  logic [ITEM_W-1:0] sel,
    output logic              empty
);
    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    // NOTE: this array is reset because its power-up contents are architectural
    // state; plain data memories without a defined start value should not be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec) begin
            stock[sel] <= stock[sel] - 1'b1;
        end
    end

    assign empty = (stock[sel] == '0);

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending-machine controller with credit carry-over, saturation
// and an insufficient-funds hold. Define VM_STOCK_EN for per-item stock tracking.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = $clog2(NUM_ITEMS),
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICE = {8'd45, 8'd20, 8'd12, 8'd3},
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ITEM_W-1:0]    item_in,
    input  logic [2:0]           money,
    input  logic                 done_money,
    input  logic                 cancel,
    input  logic                 continue_buy,
    input  logic                 restock,
    output logic                 done,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [CREDIT_W-1:0]  change,
    output logic                 coin_reject,
    output logic                 insufficient,
    output logic                 sold_out
);
    vm_state_t           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ITEM_W-1:0]   sel_q, sel_d;
    logic                reject_d, insuff_d, sold_d, sold_q;
    logic                sel_empty, stock_dec;
    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_valid;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [ITEM_W-1:0] idx);
        return ITEM_PRICE[int'(idx)*CREDIT_W +: CREDIT_W];
    endfunction

    assign price_sel  = price_of(sel_q);
    assign coin_valid = (coin_value(money) != 5'd0);
    // One extra bit so the saturation test sees the true sum.
    assign credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(money));
    assign stock_dec  = (state_q == DISPENSE);

`ifdef VM_STOCK_EN
    vm_stock #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk    (clk),
        .reset  (reset),
        .restock(restock && (state_q == IDLE)),
        .dec    (stock_dec),
        .sel    (sel_q),
        .empty  (sel_empty)
    );
`else
    // Infinite stock: the sold-out path can never fire.
    logic unused_stock;
    assign unused_stock = restock ^ stock_dec;
    assign sel_empty    = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        insuff_d = 1'b0;
        sold_d   = 1'b0;
        case (state_q)
            IDLE: begin
                credit_d = '0;
                if (start) begin
                    sel_d   = item_in;
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                if (cancel) begin
                    state_d = REFUND;
                end else begin
                    if (coin_valid) begin
                        if (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) credit_d = credit_sum[CREDIT_W-1:0];
                        else reject_d = 1'b1;
                    end
                    if (done_money) state_d = CHECK;
                end
            end
            CHECK: begin
                if (sel_empty) begin
                    sold_d  = 1'b1;
                    state_d = REFUND;
                end else if (credit_q < price_sel) begin
                    insuff_d = 1'b1;
                    state_d  = RECEIVE;
                end else begin
                    state_d = DISPENSE;
                end
            end
            DISPENSE: begin
                if (continue_buy) begin
                    credit_d = credit_q - price_sel;
                    sel_d    = item_in;
                    state_d  = RECEIVE;
                end else begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            REFUND: begin
                credit_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            sel_q        <= '0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            sold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            sel_q        <= sel_d;
            coin_reject  <= reject_d;
            insufficient <= insuff_d;
            sold_q       <= sold_d;
        end
    end

    assign sold_out = sold_q;

    // Transaction outputs decode registered state only; CHECK guarantees no underflow.
    always_comb begin
        done     = 1'b0;
        item_out = '0;
        change   = '0;
        if (state_q == DISPENSE) begin
            done     = 1'b1;
            item_out = NUM_ITEMS'(1) << sel_q;
            change   = credit_q - price_sel;
        end else if (state_q == REFUND) begin
            done   = 1'b1;
            change = credit_q;
        end
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param: directed scenarios followed by
// randomized transactions against a transaction-level credit/stock model.
module tb_vending_machine_param;
    import vm_pkg::*;

    localparam int NUM_ITEMS  = 4;
    localparam int ITEM_W     = 2;
    localparam int CREDIT_W   = 8;
    localparam int MAX_CREDIT = 200;
    localparam int STOCK_INIT = 1;
`ifdef VM_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    int price_tab [NUM_ITEMS] = '{3, 12, 20, 45};

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [ITEM_W-1:0]    item_in = '0;
    logic [2:0]           money = '0;
    logic                 done_money = 1'b0;
    logic                 cancel = 1'b0;
    logic                 continue_buy = 1'b0;
    logic                 restock = 1'b0;
    logic                 done;
    logic [NUM_ITEMS-1:0] item_out;
    logic [CREDIT_W-1:0]  change;
    logic                 coin_reject;
    logic                 insufficient;
    logic                 sold_out;

    vending_machine_param #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .CREDIT_W  (CREDIT_W),
        .MAX_CREDIT(MAX_CREDIT),
        .ITEM_PRICE({8'd45, 8'd20, 8'd12, 8'd3}),
        .STOCK_W   (4),
        .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .item_in     (item_in),
        .money       (money),
        .done_money  (done_money),
        .cancel      (cancel),
        .continue_buy(continue_buy),
        .restock     (restock),
        .done        (done),
        .item_out    (item_out),
        .change      (change),
        .coin_reject (coin_reject),
        .insufficient(insufficient),
        .sold_out    (sold_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Transaction-level model: running credit, selected item, stock per item.
    int m_credit;
    int m_sel;
    int m_stock [NUM_ITEMS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input logic [2:0] c);
        if (c == 3'b001) return 5;
        if (c == 3'b010) return 10;
        if (c == 3'b100) return 20;
        return 0;
    endfunction

    function automatic bit avail(input int i);
        return !STOCK_EN || (m_stock[i] > 0);
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_sel    = 0;
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
    endtask

    task automatic model_coin(input logic [2:0] c, output logic rej);
        int v;
        v   = coin_val(c);
        rej = 1'b0;
        if (v != 0) begin
            if (m_credit + v <= MAX_CREDIT) m_credit += v;
            else rej = 1'b1;
        end
    endtask

    task automatic do_restock();
        restock = 1'b1;
        tick();
        restock = 1'b0;
        if (STOCK_EN) for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_INIT;
        check("restock_done", done, 0);
    endtask

    task automatic do_start(input int item);
        start   = 1'b1;
        item_in = ITEM_W'(item);
        tick();
        start    = 1'b0;
        m_credit = 0;
        m_sel    = item;
        check("start_done", done, 0);
    endtask

    task automatic insert(input logic [2:0] c);
        logic rej;
        money = c;
        tick();
        money = '0;
        model_coin(c, rej);
        check("coin_reject", coin_reject, rej);
        check("coin_done", done, 0);
    endtask

    // outcome: 0 insufficient (back in RECEIVE), 1 dispensing, 2 sold-out refund completed
    task automatic finish_money(input logic [2:0] c, output int outcome);
        logic rej;
        done_money = 1'b1;
        money      = c;
        tick();
        done_money = 1'b0;
        money      = '0;
        model_coin(c, rej);
        check("dm_coin_reject", coin_reject, rej);
        check("check_done", done, 0);
        tick();
        if (!avail(m_sel)) begin
            outcome = 2;
            check("sold_out_pulse", sold_out, 1);
            check("sold_out_done", done, 1);
            check("sold_out_item", item_out, 0);
            check("sold_out_change", change, m_credit);
            m_credit = 0;
            tick();
            check("sold_out_idle", done, 0);
        end else if (m_credit < price_tab[m_sel]) begin
            outcome = 0;
            check("insufficient_pulse", insufficient, 1);
            check("insufficient_done", done, 0);
        end else begin
            outcome = 1;
            check("dispense_done", done, 1);
            check("dispense_item", item_out, 1 << m_sel);
            check("dispense_change", change, m_credit - price_tab[m_sel]);
            check("dispense_no_insuff", insufficient, 0);
            check("dispense_no_sold", sold_out, 0);
        end
    endtask

    task automatic end_dispense(input bit cont, input int next_item);
        continue_buy = cont;
        item_in      = ITEM_W'(next_item);
        tick();
        continue_buy = 1'b0;
        if (STOCK_EN) m_stock[m_sel]--;
        if (cont) begin
            m_credit -= price_tab[m_sel];
            m_sel     = next_item;
        end else begin
            m_credit = 0;
        end
        check("post_dispense_done", done, 0);
    endtask

    task automatic do_cancel(input logic [2:0] c);
        cancel = 1'b1;
        money  = c;
        tick();
        cancel = 1'b0;
        money  = '0;
        check("refund_done", done, 1);
        check("refund_item", item_out, 0);
        check("refund_change", change, m_credit);
        m_credit = 0;
        tick();
        check("refund_idle", done, 0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("areset_done", done, 0);
        check("areset_item", item_out, 0);
        check("areset_change", change, 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int  o;
        bit  active;
        bit  cont;

        // Power-on reset
        model_reset();
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_item", item_out, 0);
        check("rst_change", change, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_insuff", insufficient, 0);
        check("rst_sold", sold_out, 0);
        reset = 1'b0;

        // Reset mid-RECEIVE with credit 15; the next purchase must start from 0
        do_start(1);
        insert(COIN_10);
        insert(COIN_5);
        async_reset();
        do_start(1);
        insert(COIN_10);
        finish_money(3'b000, o);
        do_cancel(3'b000);

        // Basic purchase, then asynchronous reset while dispensing
        do_restock();
        do_start(1);
        insert(COIN_10);
        insert(COIN_5);
        finish_money(3'b000, o);
        async_reset();

        // Insufficient funds hold, then top-up
        do_start(3);
        insert(COIN_20);
        finish_money(3'b000, o);
        insert(COIN_20);
        insert(COIN_10);
        finish_money(3'b000, o);
        if (o == 1) end_dispense(1'b0, 0);

        // Chained purchase
        do_restock();
        do_start(0);
        insert(COIN_20);
        finish_money(3'b000, o);
        if (o == 1) end_dispense(1'b1, 1);
        finish_money(3'b000, o);
        if (o == 1) end_dispense(1'b0, 0);

        // Invalid coin then cancel
        do_start(2);
        insert(COIN_20);
        insert(COIN_10);
        insert(3'b011);
        do_cancel(3'b000);

        // Saturation at the credit ceiling; coin with cancel is ignored
        do_start(3);
        for (int i = 0; i < 10; i++) insert(COIN_20);
        insert(COIN_5);
        do_cancel(COIN_5);

        // Sold out and restock of item 2
        do_restock();
        for (int k = 0; k < 2; k++) begin
            do_start(2);
            insert(COIN_20);
            finish_money(3'b000, o);
            if (o == 1) end_dispense(1'b0, 0);
        end
        do_restock();
        do_start(2);
        insert(COIN_20);
        finish_money(3'b000, o);
        if (o == 1) end_dispense(1'b0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) do_restock();
            do_start(int'($urandom_range(0, 3)));
            active = 1'b1;
            for (int r = 0; r < 4 && active; r++) begin
                int n;
                n = int'($urandom_range(0, 5));
                for (int c = 0; c < n; c++) insert(3'($urandom_range(0, 7)));
                if ($urandom_range(0, 5) == 0) begin
                    do_cancel(3'($urandom_range(0, 7)));
                    active = 1'b0;
                end else begin
                    finish_money(3'($urandom_range(0, 7)), o);
                    if (o == 2) begin
                        active = 1'b0;
                    end else if (o == 1) begin
                        cont = 1'($urandom_range(0, 1));
                        end_dispense(cont, int'($urandom_range(0, 3)));
                        if (!cont) active = 1'b0;
                    end
                end
            end
            if (active) do_cancel(3'b000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
